// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory_unit between the memory traversal unit (port A) and the
// Nock execution module (port B). One transaction runs at a time through a
// request/grant/done handshake; the read result and free address of the last
// completed transaction stay latched for the requester.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_x, func_x, addr_x,       requester side (x = a: MTU, x = b: NEM)
//   wdata_x
//   grant_x, done_x              grant (issue..done inclusive), done pulse
//   rdata, rfree_addr            latched read_data / free_addr
//   mem_ready, mem_read_data,    memory_unit status and results
//   mem_free_addr
//   mem_execute, mem_func,       registered command to memory_unit
//   mem_address, mem_write_data
//   busy                         high whenever the arbiter is not idle
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise port A has fixed priority.

`timescale 1ns/1ps

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_arbiter #(
    parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W = `MEMORY_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [1:0]        func_a,
    input  logic [1:0]        func_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              grant_a,
    output logic              grant_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rfree_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [ADDR_W-1:0] mem_free_addr,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              busy
);

    // state       | meaning
    // S_IDLE      | waiting for a request while memory is ready
    // S_ISSUE     | execute pulse to memory, winner's command on mem_*
    // S_WAIT_BUSY | waiting for memory to drop ready (command accepted)
    // S_WAIT_DONE | waiting for memory to raise ready (result available)
    // S_DONE      | done pulse to winner, grant released
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   win_b;      // 1: current/last transaction belongs to port B
    logic   sel_b;      // arbitration choice, meaningful only with a request pending
    logic   take;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic pref_b;       // port favoured on the next simultaneous request

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pref_b <= 1'b0;
        else if (state == S_DONE)
            pref_b <= ~win_b;
    end

    always_comb begin
        sel_b = req_b;
        if (req_a && req_b)
            sel_b = pref_b;
    end
`else
    always_comb begin
        sel_b = ~req_a;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (mem_ready && (req_a || req_b)) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!mem_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (mem_ready) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign take = (state == S_IDLE) && (state_nxt == S_ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            win_b          <= 1'b0;
            mem_func       <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            rdata          <= '0;
            rfree_addr     <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                win_b          <= sel_b;
                mem_func       <= sel_b ? func_b  : func_a;
                mem_address    <= sel_b ? addr_b  : addr_a;
                mem_write_data <= sel_b ? wdata_b : wdata_a;
            end
            if ((state == S_WAIT_DONE) && mem_ready) begin
                rdata      <= mem_read_data;
                rfree_addr <= mem_free_addr;
            end
        end
    end

    // All handshake outputs decode the state register only.
    assign busy        = (state != S_IDLE);
    assign grant_a     = busy && !win_b;
    assign grant_b     = busy && win_b;
    assign done_a      = (state == S_DONE) && !win_b;
    assign done_b      = (state == S_DONE) && win_b;
    assign mem_execute = (state == S_ISSUE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory_unit` between the memory traversal unit (port A, MTU) and the Nock execution module (port B, NEM). It replaces the static `memory_mux` and its externally driven select. Each requester gets a request/grant/done handshake, and the arbiter sequences exactly one memory transaction at a time. Read results are latched so that they stay stable for the requester after the memory moves on.

## Interface
Parameters:
- `ADDR_W`, default `` `memory_addr_width ``: address width, taken from `memory_unit.vh`.
- `DATA_W`, default `` `memory_data_width ``: data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a`, `req_b`  in  1  transaction request from MTU / NEM.
- `func_a`, `func_b`  in  2  memory function code, passed through to `memory_unit`.
- `addr_a`, `addr_b`  in  ADDR_W  request address.
- `wdata_a`, `wdata_b`  in  DATA_W  request write data.
- `grant_a`, `grant_b`  out  1  high from issue until done, inclusive; at most one is high.
- `done_a`, `done_b`  out  1  one-cycle pulse when the granted transaction completes.
- `rdata`  out  DATA_W  latched `read_data` of the last completed transaction.
- `rfree_addr`  out  ADDR_W  latched `free_addr` of the last completed transaction.
- `mem_ready`  in  1  `is_ready` from `memory_unit`.
- `mem_read_data`  in  DATA_W  `read_data` from `memory_unit`.
- `mem_free_addr`  in  ADDR_W  `free_addr` from `memory_unit`.
- `mem_execute`  out  1  registered one-cycle execute pulse to `memory_unit`.
- `mem_func`  out  2  registered function code.
- `mem_address`  out  ADDR_W  registered address.
- `mem_write_data`  out  DATA_W  registered write data.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.

- **IDLE**
  - Stays in IDLE while `mem_ready` = 0 or no request is pending.
  - Otherwise selects a winner. With `req_a` and `req_b` both high, the winner is set by the configured policy (see Configuration).
  - Registers the winner's `func`, `addr` and `wdata` into the `mem_*` outputs.
  - Asserts the winner's grant and goes to ISSUE.
- **ISSUE**: `mem_execute` = 1 for exactly this cycle. Next state is WAIT_BUSY.
- **WAIT_BUSY**: waits for `mem_ready` = 0 (memory accepted the command), then goes to WAIT_DONE.
- **WAIT_DONE**
  - Waits for `mem_ready` = 1.
  - On that edge, latches `mem_read_data` into `rdata` and `mem_free_addr` into `rfree_addr`, then goes to DONE.
- **DONE**: pulses the winner's `done_x` for one cycle, drops its grant, returns to IDLE.

Handshake and data rules:
- A requester must hold `req_x`, `func_x`, `addr_x` and `wdata_x` stable from assertion until it sees `grant_x`. Inputs are sampled only in IDLE.
- If `req_x` is still high in the cycle after `done_x`, it is treated as a new request and re-arbitrated.
- If `req_x` deasserts mid-transaction, the transaction still completes and `done_x` still pulses.
- `rdata` and `rfree_addr` hold their values until the next WAIT_DONE→DONE transition. This applies to every function code, including writes.
- `mem_func`, `mem_address` and `mem_write_data` hold their values after ISSUE until the next grant.

Reset:
- Asserting `rst` at any time, including mid-transaction, forces IDLE immediately.
- Outputs under reset: all outputs = 0, including `rdata`, `rfree_addr` and the round-robin pointer.
- An interrupted transaction produces no `done` pulse. The requester must reissue it after reset.

## Timing
- From `req_x` high in IDLE with `mem_ready` = 1: `grant_x` is high after edge 1, and `mem_execute` is high during cycle 2.
- Minimum request-to-done latency is 4 cycles plus the memory busy time.
- Back-to-back transactions have 1 IDLE cycle between DONE and the next grant.
- `grant_x` and `done_x` come from the state register only; there is no combinational path from the inputs.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- Defined:
  - Round-robin arbitration. A 1-bit last-winner pointer updates in DONE.
  - On a simultaneous request, the port that did not win last is granted.
  - After reset the pointer favours A.
- Undefined:
  - Fixed priority: port A (MTU) always wins a simultaneous request.
  - No pointer register is built.

## Test plan
1. **Reset.** Hold `rst`=1 with random inputs → all outputs 0. Release with `mem_ready`=1 and no requests → IDLE, `busy`=0.
2. **Single read on A.** Pulse `req_a` with `addr_a`=1, `func_a`=0. The memory model goes busy for 3 cycles and returns 0xABCD.
   - Required: `grant_a` next cycle; one `mem_execute` pulse with `mem_address`=1; `done_a` pulse; `rdata`=0xABCD held afterwards.
   - `grant_b` and `done_b` stay 0 throughout.
3. **Simultaneous requests, 4 transactions.** Hold `req_a` and `req_b` high for 4 transactions.
   - With the macro: grant order A, B, A, B.
   - Without the macro: A, A, A, A, and B is never granted.
4. **Request while not ready.** Raise `req_b` while `mem_ready`=0 → no grant until `mem_ready` rises, then grant exactly 1 cycle later.
5. **Reset mid-transaction.** Assert `rst` during WAIT_DONE → `grant`, `busy` and `mem_execute` = 0 immediately, with no `done` pulse. Re-issuing after release completes normally.
6. **Request dropped mid-transaction.** Drop `req_a` during WAIT_BUSY → transaction completes; `done_a` still pulses once; arbiter returns to IDLE and does not re-grant A.
